// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle for bit_serializer.
// master: the producer side (drives data_in/data_valid, observes the rest).
// slave : the serializer itself.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  ser_out,
    input  ser_valid,
    input  word_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output ser_out,
    output ser_valid,
    output word_done
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: converts WIDTH-bit words into a contiguous serial bit stream.
// A one-word hold buffer lets the producer hand over the next word while the
// current one is still shifting, so back-to-back words leave no gap cycle.
// Optional build macro SERIALIZER_LSB_FIRST_EN: emit LSB first instead of MSB
// first; handshake and timing are identical in both builds.
// clr is a synchronous active-high reset and blocks any accept on its edge.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  bit_serializer_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shift_r, shift_nxt_s;
  logic [WIDTH-1:0] hold_r, hold_nxt_s;
  logic             hold_full_r, hold_full_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             ser_out_r, ser_valid_r, word_done_r;
  logic             ser_out_nxt_s, ser_valid_nxt_s, word_done_nxt_s;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;
  logic             next_bit_s;

  // Ready depends only on registered state; clr suppresses any accept.
  assign bus.data_ready = ~hold_full_r;
  assign accept_s       = bus.data_valid & ~hold_full_r & ~clr;

`ifdef SERIALIZER_LSB_FIRST_EN
  assign shifted_s  = {1'b0, shift_r[WIDTH-1:1]};
  assign next_bit_s = shift_nxt_s[0];
`else
  assign shifted_s  = {shift_r[WIDTH-2:0], 1'b0};
  assign next_bit_s = shift_nxt_s[WIDTH-1];
`endif

  // Next-state, datapath and output decode for the IDLE/SHIFT machine.
  always_comb begin
    state_nxt_s     = state_r;
    shift_nxt_s     = shift_r;
    hold_nxt_s      = hold_r;
    hold_full_nxt_s = hold_full_r;
    cnt_nxt_s       = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_nxt_s = bus.data_in;
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_IDX) begin
          cnt_nxt_s = {CW{1'b0}};
          // A held word wins; ready is low this cycle so accept_s is 0 then.
          if (hold_full_r) begin
            shift_nxt_s     = hold_r;
            hold_full_nxt_s = 1'b0;
          end else if (accept_s) begin
            shift_nxt_s = bus.data_in;
          end else begin
            shift_nxt_s = {WIDTH{1'b0}};
            state_nxt_s = IDLE;
          end
        end else begin
          shift_nxt_s = shifted_s;
          cnt_nxt_s   = cnt_r + CNT_ONE;
          if (accept_s) begin
            hold_nxt_s      = bus.data_in;
            hold_full_nxt_s = 1'b1;
          end else begin
            hold_full_nxt_s = hold_full_r;
          end
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        shift_nxt_s     = {WIDTH{1'b0}};
        hold_full_nxt_s = 1'b0;
        cnt_nxt_s       = {CW{1'b0}};
      end
    endcase

    // Outputs are precomputed so they can be driven straight from flops.
    ser_valid_nxt_s = (state_nxt_s == SHIFT);
    ser_out_nxt_s   = ser_valid_nxt_s & next_bit_s;
    word_done_nxt_s = ser_valid_nxt_s & (cnt_nxt_s == LAST_IDX);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers; clr discards anything in flight or held.
  always_ff @(posedge clk) begin
    if (clr) begin
      shift_r     <= {WIDTH{1'b0}};
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      ser_out_r   <= 1'b0;
      ser_valid_r <= 1'b0;
      word_done_r <= 1'b0;
    end else begin
      shift_r     <= shift_nxt_s;
      hold_r      <= hold_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ser_out_r   <= ser_out_nxt_s;
      ser_valid_r <= ser_valid_nxt_s;
      word_done_r <= word_done_nxt_s;
    end
  end

  assign bus.ser_out   = ser_out_r;
  assign bus.ser_valid = ser_valid_r;
  assign bus.word_done = word_done_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8).
// A table of words with their expected serial sequences feeds a scoreboard
// queue on every accept; a monitor pops and compares on every falling edge.
module tb_bit_serializer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] msb_seq;   // expected ser_out order, first bit on the left
    logic [7:0] lsb_seq;
  } vec_t;

  typedef struct packed {
    logic bit_v;
    logic last;
  } exp_t;

  vec_t       vecs [11];
  exp_t       sb_q [$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         bits_seen = 0;
  int         accepts_seen = 0;
  logic       mon_en = 1'b0;
  logic [7:0] cur_seq = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] seq_of(input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
    return vecs[i].lsb_seq;
`else
    return vecs[i].msb_seq;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer up to three table words back to back, data_valid held high.
  task automatic send_stream(input int a, input int b, input int c, input int n);
    int ia [3];
    int k;
    int guard;
    logic acc;
    ia[0] = a; ia[1] = b; ia[2] = c;
    k = 0;
    guard = 0;
    while (k < n && guard < 200) begin
      bus.data_valid = 1'b1;
      bus.data_in    = vecs[ia[k]].word;
      cur_seq        = seq_of(ia[k]);
      @(negedge clk);
      acc = bus.data_ready;
      cycle();
      if (acc) k++;
      guard++;
    end
    if (guard >= 200) check("stream_timeout", 32'd0, 32'd1);
    bus.data_valid = 1'b0;
    bus.data_in    = 8'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || bus.ser_valid) && g < 100) begin
      cycle();
      g++;
    end
    if (g >= 100) check("idle_timeout", 32'd0, 32'd1);
    cycle();
  endtask

  // Falling-edge scoreboard monitor: compare, then record the coming accept.
  task automatic monitor();
    exp_t e;
    logic exp_valid;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_valid = (sb_q.size() != 0);
        check("ser_valid", 32'(bus.ser_valid), 32'(exp_valid));
        check("data_ready", 32'(bus.data_ready), 32'(sb_q.size() <= WIDTH));
        if (exp_valid) begin
          e = sb_q.pop_front();
          check("ser_out", 32'(bus.ser_out), 32'(e.bit_v));
          check("word_done", 32'(bus.word_done), 32'(e.last));
        end else begin
          check("ser_out_idle", 32'(bus.ser_out), 32'd0);
          check("word_done_idle", 32'(bus.word_done), 32'd0);
        end
        if (bus.ser_valid) bits_seen++;
        if (clr) begin
          sb_q.delete();
        end else if (bus.data_valid && bus.data_ready) begin
          accepts_seen++;
          for (int i = 7; i >= 0; i--) sb_q.push_back('{bit_v: cur_seq[i], last: (i == 0)});
        end
      end
    end
  endtask

  initial begin
    vecs[0]  = '{word: 8'h33, msb_seq: 8'b0011_0011, lsb_seq: 8'b1100_1100};
    vecs[1]  = '{word: 8'h0F, msb_seq: 8'b0000_1111, lsb_seq: 8'b1111_0000};
    vecs[2]  = '{word: 8'hC3, msb_seq: 8'b1100_0011, lsb_seq: 8'b1100_0011};
    vecs[3]  = '{word: 8'hA5, msb_seq: 8'b1010_0101, lsb_seq: 8'b1010_0101};
    vecs[4]  = '{word: 8'h01, msb_seq: 8'b0000_0001, lsb_seq: 8'b1000_0000};
    vecs[5]  = '{word: 8'h80, msb_seq: 8'b1000_0000, lsb_seq: 8'b0000_0001};
    vecs[6]  = '{word: 8'h0C, msb_seq: 8'b0000_1100, lsb_seq: 8'b0011_0000};
    vecs[7]  = '{word: 8'hFF, msb_seq: 8'b1111_1111, lsb_seq: 8'b1111_1111};
    vecs[8]  = '{word: 8'h00, msb_seq: 8'b0000_0000, lsb_seq: 8'b0000_0000};
    vecs[9]  = '{word: 8'hAA, msb_seq: 8'b1010_1010, lsb_seq: 8'b0101_0101};
    vecs[10] = '{word: 8'hF0, msb_seq: 8'b1111_0000, lsb_seq: 8'b0000_1111};

    fork
      monitor();
    join_none

    // Reset for two cycles; a valid word offered during clr must be ignored.
    clr            = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hA5;
    cycle();
    cycle();
    clr            = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    check("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
    check("rst_ser_out", 32'(bus.ser_out), 32'd0);
    check("rst_word_done", 32'(bus.word_done), 32'd0);
    check("rst_data_ready", 32'(bus.data_ready), 32'd1);
    cycle();
    mon_en = 1'b1;

    // Table: single words, each checked bit by bit by the scoreboard.
    for (int i = 0; i < 7; i++) begin
      bits_seen = 0;
      send_stream(i, 0, 0, 1);
      wait_idle();
      check("bits_per_word", 32'(bits_seen), 32'd8);
    end

    // Two words on consecutive cycles: second is held, no gap between them.
    bits_seen = 0;
    send_stream(1, 2, 0, 2);
    wait_idle();
    check("pair_bits", 32'(bits_seen), 32'd16);

    // Valid held high across three words: each accepted exactly once.
    bits_seen    = 0;
    accepts_seen = 0;
    send_stream(7, 8, 9, 3);
    wait_idle();
    check("triple_bits", 32'(bits_seen), 32'd24);
    check("triple_accepts", 32'(accepts_seen), 32'd3);

    // clr on the 4th bit of 8'h33 while 8'hF0 sits in the hold buffer.
    bus.data_valid = 1'b1;
    bus.data_in    = vecs[0].word;
    cur_seq        = seq_of(0);
    @(negedge clk);
    check("ready_before_33", 32'(bus.data_ready), 32'd1);
    cycle();
    bus.data_in = vecs[10].word;
    cur_seq     = seq_of(10);
    @(negedge clk);
    check("ready_for_f0", 32'(bus.data_ready), 32'd1);
    cycle();
    bus.data_valid = 1'b0;
    bus.data_in    = 8'($urandom);
    cycle();
    cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    bits_seen = 0;
    @(negedge clk);
    check("clr_ser_valid", 32'(bus.ser_valid), 32'd0);
    check("clr_ser_out", 32'(bus.ser_out), 32'd0);
    check("clr_data_ready", 32'(bus.data_ready), 32'd1);
    repeat (20) cycle();
    check("clr_no_bits", 32'(bits_seen), 32'd0);

    // clr together with a valid word: nothing may be accepted or emitted.
    clr            = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = vecs[7].word;
    cur_seq        = seq_of(7);
    cycle();
    clr            = 1'b0;
    bus.data_valid = 1'b0;
    bits_seen      = 0;
    repeat (12) cycle();
    check("clr_blocks_accept", 32'(bits_seen), 32'd0);

    // Stream resumes normally after reset.
    bits_seen = 0;
    send_stream(3, 6, 0, 2);
    wait_idle();
    check("post_clr_bits", 32'(bits_seen), 32'd16);
    check("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per parallel word (legal range 2..16).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 data_in  input  WIDTH  parallel word offered by the producer.
REQ-005 data_valid  input  1  producer asserts when data_in holds a word.
REQ-006 data_ready  output  1  block can accept a word this cycle.
REQ-007 ser_out  output  1  serial bit stream, drives the sequence detector's A input.
REQ-008 ser_valid  output  1  ser_out carries a payload bit this cycle.
REQ-009 word_done  output  1  one-cycle pulse with the last bit of each word.

Function
REQ-010 The block SHALL contain a WIDTH-bit shift register, a WIDTH-bit hold buffer with full flag, a bit counter 0..WIDTH-1 and a two-state FSM: IDLE, SHIFT.
REQ-011 A word SHALL be accepted on a rising edge where data_valid=1 and data_ready=1; data_ready SHALL equal NOT hold_full (combinational from registered state only).
REQ-012 IDLE: an accepted word SHALL load the shift register directly, counter=0, FSM->SHIFT; its first bit SHALL appear on ser_out the cycle after acceptance (latency 1).
REQ-013 SHIFT: each cycle SHALL present one bit on ser_out with ser_valid=1 and advance the counter; default order is MSB first.
REQ-014 SHIFT, word accepted while not on the last bit: word SHALL go to the hold buffer, hold_full=1.
REQ-015 Last bit (counter=WIDTH-1): word_done=1; next cycle the shift register SHALL load from the hold buffer if full (hold_full cleared), else from a word accepted this same cycle, else FSM->IDLE.
REQ-016 Back-to-back words SHALL be emitted with no gap cycle when the next word is accepted no later than the last-bit cycle of the current word.
REQ-017 Simultaneous: last-bit cycle with hold_full=1 SHALL not accept (data_ready=0); hold buffer moves to shifter, data_ready rises next cycle.
REQ-018 IDLE: ser_out=0, ser_valid=0, word_done=0.
REQ-019 data_in SHALL be sampled only on an accepting edge; later changes SHALL not affect emitted bits.

Reset
REQ-020 clr=1 at a rising edge SHALL force FSM=IDLE, counter=0, hold_full=0, shift register=0, hold buffer=0.
REQ-021 Outputs after reset: ser_out=0, ser_valid=0, word_done=0, data_ready=1.
REQ-022 clr SHALL take priority over a simultaneous accept; a word in flight or held SHALL be discarded with no further bits emitted.
REQ-023 No accept SHALL occur on any edge where clr=1.

Configuration
REQ-024 Macro SERIALIZER_LSB_FIRST_EN: when defined, bits SHALL be emitted LSB first; when undefined, MSB first; handshake and timing identical in both builds.

Verification
REQ-025 clr=1 two cycles, then data_in=8'h33 valid one cycle -> ser_out 0,0,1,1,0,0,1,1 on the 8 following cycles, ser_valid high exactly 8 cycles, word_done on 8th.
REQ-026 8'h0F then 8'hC3 offered on consecutive cycles -> second held, data_ready=0 until last bit of first, 16 contiguous valid bits 00001111 11000011, no gap.
REQ-027 data_valid held high with 8'hFF, 8'h00, 8'hAA -> each word accepted once, exactly 24 payload bits, data_ready low while hold buffer full.
REQ-028 clr asserted on 4th bit of 8'h33 with 8'hF0 held -> next cycle ser_valid=0, ser_out=0, data_ready=1; 8'hF0 never emitted.
REQ-029 Build with SERIALIZER_LSB_FIRST_EN, send 8'h0C -> ser_out 0,0,1,1,0,0,0,0; chained into detector, detector out pulses once on the 4th bit.
